execute_stage: RTL and testbench



---
 rtl/y86_pkg.sv | 34 +++
 rtl/execute_stage_cond_eval.sv | 28 ++
 rtl/execute_stage.sv | 92 +++++++++
 tb/tb_execute_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU functions,
// branch conditions and the condition-code reset value.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // cc is packed as {ZF, SF, OF}
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/execute_stage_cond_eval.sv
// Branch/cmov condition evaluator: maps a condition ifun and the registered
// {ZF,SF,OF} flags to a single condition-true bit. Purely combinational.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] cc,
  output logic       cond
);

  logic zf, sf, of;
  assign {zf, sf, of} = cc;

  always_comb begin
    cond = 1'b0;
    case (ifun)
      C_YES:   cond = 1'b1;
      C_LE:    cond = (sf ^ of) | zf;
      C_L:     cond = sf ^ of;
      C_E:     cond = zf;
      C_NE:    cond = ~zf;
      C_GE:    cond = ~(sf ^ of);
      C_G:     cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU producing valE, condition-code register and Cnd.
// Define EXECUTE_REG_OUT_EN to register valE/Cnd for one cycle of latency.
module execute_stage
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic [W-1:0] valE,
  output logic         Cnd,
  output logic [2:0]   cc
);

  localparam logic [W-1:0] STACK_STEP = W'(8);

  logic [W-1:0] op_res;
  logic         op_valid;
  logic         op_of;
  logic [W-1:0] val_e_c;
  logic         cond_true;
  logic         cnd_c;

  always_comb begin
    op_res   = '0;
    op_valid = 1'b1;
    op_of    = 1'b0;
    case (ifun)
      ALU_ADD: begin
        op_res = valB + valA;
        op_of  = (valA[W-1] == valB[W-1]) & (op_res[W-1] != valB[W-1]);
      end
      ALU_SUB: begin
        op_res = valB - valA;
        op_of  = (valA[W-1] != valB[W-1]) & (op_res[W-1] != valB[W-1]);
      end
      ALU_AND: op_res = valB & valA;
      ALU_XOR: op_res = valB ^ valA;
      default: op_valid = 1'b0;
    endcase
  end

  always_comb begin
    val_e_c = '0;
    case (icode)
      I_RRMOVQ:          val_e_c = valA;
      I_IRMOVQ:          val_e_c = valC;
      I_RMMOVQ, I_MRMOVQ: val_e_c = valB + valC;
      I_OPQ:             val_e_c = op_res;
      I_CALL, I_PUSHQ:   val_e_c = valB - STACK_STEP;
      I_RET, I_POPQ:     val_e_c = valB + STACK_STEP;
      default:           val_e_c = '0;
    endcase
  end

  // Conditions see the flags from before this cycle's OPq update
  cond_eval u_cond_eval (
    .ifun (ifun),
    .cc   (cc),
    .cond (cond_true)
  );

  assign cnd_c = ((icode == I_RRMOVQ) || (icode == I_JXX)) & cond_true;

  always_ff @(posedge clk) begin
    if (rst)
      cc <= CC_RESET;
    else if ((icode == I_OPQ) && op_valid)
      cc <= {(op_res == '0), op_res[W-1], op_of};
  end

`ifdef EXECUTE_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      valE <= '0;
      Cnd  <= 1'b0;
    end else begin
      valE <= val_e_c;
      Cnd  <= cnd_c;
    end
  end
`else
  assign valE = val_e_c;
  assign Cnd  = cnd_c;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage (combinational-output build): directed
// cases followed by randomized instructions against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic [63:0] valE;
  logic        Cnd;
  logic [2:0]  cc;

  int checks = 0;
  int failures = 0;
  logic [2:0] mcc;

  execute_stage #(.W(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .valE  (valE),
    .Cnd   (Cnd),
    .cc    (cc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish (actual running, required finished)");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [63:0] modelValE(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
    logic [63:0] r;
    r = 64'd0;
    case (ic)
      4'h2: r = a;
      4'h3: r = c;
      4'h4, 4'h5: r = b + c;
      4'h6: begin
        if (fn == 4'd0) r = b + a;
        else if (fn == 4'd1) r = b - a;
        else if (fn == 4'd2) r = b & a;
        else if (fn == 4'd3) r = b ^ a;
      end
      4'h8, 4'hA: r = b - 64'd8;
      4'h9, 4'hB: r = b + 64'd8;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Flags from a mathematically exact signed result: OF means it does not fit in 64 bits
  function automatic logic [2:0] modelFlags(input logic [3:0] fn, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [63:0] r;
    logic signed [65:0] exact;
    logic zf, sf, of;
    r = modelValE(4'h6, fn, a, b, 64'd0);
    zf = (r == 64'd0);
    sf = r[63];
    of = 1'b0;
    if (fn == 4'd0) begin
      exact = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
      of = (exact != $signed({{2{r[63]}}, r}));
    end else if (fn == 4'd1) begin
      exact = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
      of = (exact != $signed({{2{r[63]}}, r}));
    end
    return {zf, sf, of};
  endfunction

  function automatic logic modelCnd(input logic [3:0] ic, input logic [3:0] fn,
                                    input logic [2:0] f);
    logic lt;
    if (ic != 4'h2 && ic != 4'h7) return 1'b0;
    lt = f[1] ^ f[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || f[2];
      4'd2: return lt;
      4'd3: return f[2];
      4'd4: return !f[2];
      4'd5: return !lt;
      4'd6: return !lt && !f[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, check combinational outputs, clock it, then check cc
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c, input logic r);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; rst = r;
    #2;
    checkOutput("valE", valE, modelValE(ic, fn, a, b, c));
    checkOutput("Cnd", {63'd0, Cnd}, {63'd0, modelCnd(ic, fn, mcc)});
    @(posedge clk);
    #1;
    if (r) mcc = 3'b100;
    else if (ic == 4'h6 && fn <= 4'd3) mcc = modelFlags(fn, a, b);
    checkOutput("cc", {61'd0, cc}, {61'd0, mcc});
  endtask

  initial begin
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0; rst = 1'b1;
    @(posedge clk);
    #1;
    mcc = 3'b100;
    checkOutput("reset_cc", {61'd0, cc}, 64'h4);

    applyStimulus(4'h2, 4'h0, 64'd120, 64'd12, 64'd35, 1'b0);
    checkOutput("rrmov_valE", valE, 64'd120);
    checkOutput("rrmov_Cnd", {63'd0, Cnd}, 64'd1);

    applyStimulus(4'h6, 4'h1, 64'd12, 64'd12, 64'd0, 1'b0);
    checkOutput("sub_zero_cc", {61'd0, cc}, 64'h4);
    applyStimulus(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b0);
    checkOutput("je_taken", {63'd0, Cnd}, 64'd1);
    applyStimulus(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1'b0);
    checkOutput("jne_not", {63'd0, Cnd}, 64'd0);

    applyStimulus(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    checkOutput("add_ovf_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("add_ovf_cc", {61'd0, cc}, 64'h3);
    applyStimulus(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b0);
    checkOutput("jl_not", {63'd0, Cnd}, 64'd0);
    applyStimulus(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 1'b0);
    checkOutput("jge_taken", {63'd0, Cnd}, 64'd1);

    applyStimulus(4'h4, 4'h0, 64'd0, 64'd100, 64'd35, 1'b0);
    checkOutput("rmmov_valE", valE, 64'd135);
    applyStimulus(4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 1'b0);
    checkOutput("call_valE", valE, 64'hF8);
    applyStimulus(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 1'b0);
    checkOutput("popq_valE", valE, 64'h100);
    checkOutput("cc_held", {61'd0, cc}, 64'h3);

    applyStimulus(4'h6, 4'h1, 64'd12, 64'd5, 64'd0, 1'b0);
    checkOutput("sub_neg_cc", {61'd0, cc}, 64'h2);
    applyStimulus(4'h6, 4'h1, 64'd12, 64'd5, 64'd0, 1'b1);
    checkOutput("reset_prio_cc", {61'd0, cc}, 64'h4);
    applyStimulus(4'h2, 4'h2, 64'd7, 64'd0, 64'd0, 1'b0);
    checkOutput("cmovl_after_rst", {63'd0, Cnd}, 64'd0);

    applyStimulus(4'hF, 4'h0, 64'hDEAD_BEEF, 64'h1234, 64'h5678, 1'b0);
    checkOutput("invalid_valE", valE, 64'd0);
    checkOutput("invalid_Cnd", {63'd0, Cnd}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = b;
      if ($urandom_range(0, 7) == 0) a = {$urandom_range(0, 1) == 1, 63'h7FFF_FFFF_FFFF_FFFF};
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), a, b,
                    {$urandom, $urandom}, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
